// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Brief    : Instruction-fetch stage controller. Owns the PC, the imem request
//            handshake and the IF/ID register. Applies EX redirects, flushes
//            wrong-path instructions to NOP, holds fetch during stalls using a
//            one-entry skid buffer, and discards responses to requests that
//            were abandoned by a redirect (DROP state).
//            Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt and
//            perf_flush_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] ex_target,
  input  logic        branch,
  input  logic        stall_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] fetch_addr;
  logic        accept;
  logic        flush;

  // Redirect decode; the low target bits are forced to zero (word aligned)
  assign redirect   = (pc_sel == 2'b01) || (pc_sel == 2'b10);
  assign target     = (pc_sel == 2'b10) ? {TRAP_VEC[31:2], 2'b00}
                                        : {ex_target[31:2], ex_target[1:0] & 2'b00};
  assign fetch_addr = {pc_q[31:2], pc_q[1:0] & 2'b00};

  // Request is live in FETCH and while draining an abandoned request in DROP
  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_addr;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;

  // Next-state, PC, skid and IF/ID update with priority redirect > flush > stall
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    accept       = 1'b0;
    flush        = 1'b0;

    if (state_q == ST_DROP) begin
      // Old response is thrown away; a further redirect only retargets the PC
      if (redirect) begin
        pc_d = target;
      end else if (branch) begin
        flush = 1'b1;
      end
      if (imem_ready) begin
        state_d = ST_FETCH;
      end
    end else if (redirect) begin
      pc_d  = target;
      flush = 1'b1;
      if ((state_q == ST_FETCH) && !imem_ready) begin
        // Request cannot be withdrawn: keep presenting it and discard its data
        state_d     = ST_DROP;
        drop_addr_d = fetch_addr;
      end else begin
        state_d = ST_FETCH;
      end
    end else if (branch) begin
      // Kill only; any response this cycle is dropped and the PC refetched
      flush = 1'b1;
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_HOLD:  state_d = stall_en ? ST_HOLD : ST_FETCH;
        default:  state_d = state_q;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            accept = 1'b1;
            pc_d   = pc_q + 32'd4;
            if (stall_en) begin
              skid_valid_d = 1'b1;
              skid_pc_d    = fetch_addr;
              skid_instr_d = imem_rdata;
              state_d      = ST_HOLD;
            end else begin
              id_pc_d    = fetch_addr;
              id_instr_d = imem_rdata;
              id_valid_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_en) begin
            if (skid_valid_q) begin
              id_pc_d    = skid_pc_q;
              id_instr_d = skid_instr_q;
              id_valid_d = 1'b1;
            end
            skid_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end

    if (flush) begin
      id_instr_d   = NOP_INSTR;
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // State, PC, skid and IF/ID registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 32'h0;
      id_pc_q      <= 32'h0;
      id_instr_q   <= NOP_INSTR;
      id_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  // Count responses actually kept and cycles in which IF/ID was flushed
  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + {31'b0, accept};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'b0, flush};
  end

  // Performance counter registers (wrap naturally)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt_q <= 32'h0;
      perf_flush_cnt_q <= 32'h0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`else
  logic unused_cnt_sig;
  assign unused_cnt_sig = accept ^ flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_ctrl
// Brief    : Directed self-checking bench for if_fetch_ctrl. Memory returns
//            rdata = addr ^ 32'hA5A5_0000 so every instruction is traceable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] ex_target = 32'h0;
  logic        branch = 1'b0;
  logic        stall_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  if_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .ex_target  (ex_target),
    .branch     (branch),
    .stall_en   (stall_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_valid   (id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    next_cyc();
    next_cyc();
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req got %b exp 0", imem_req); end
    compared++;
    if (id_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b exp 0", id_valid); end
    compared++;
    if (id_instr !== NOP) begin mismatched++; $display("FAIL rst_instr got %h exp %h", id_instr, NOP); end
    compared++;
    if (id_pc !== 32'h0) begin mismatched++; $display("FAIL rst_pc got %h exp 0", id_pc); end
`ifdef FETCH_PERF_CNT_EN
    compared++;
    if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      mismatched++; $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    imem_ready = 1'b1;
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("FAIL idle_req got %b exp 0", imem_req); end
    next_cyc();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      mismatched++; $display("FAIL seq_first got req %b addr %h exp 1 00000000", imem_req, imem_addr);
    end
    compared++;
    if (id_valid !== 1'b0) begin mismatched++; $display("FAIL seq_valid2 got %b exp 0", id_valid); end
    next_cyc();
    compared++;
    if (imem_addr !== 32'h4 || id_pc !== 32'h0 || id_instr !== KEY || id_valid !== 1'b1) begin
      mismatched++; $display("FAIL seq_c2 got addr %h pc %h instr %h v %b exp 4 0 %h 1", imem_addr, id_pc, id_instr, id_valid, KEY);
    end
    next_cyc();
    compared++;
    if (imem_addr !== 32'h8 || id_pc !== 32'h4) begin
      mismatched++; $display("FAIL seq_c3 got addr %h pc %h exp 8 4", imem_addr, id_pc);
    end
  endtask

  task automatic test_stall();
    stall_en = 1'b1;
    next_cyc();
    compared++;
    if (imem_req !== 1'b0 || id_pc !== 32'h4) begin
      mismatched++; $display("FAIL stall_hold1 got req %b pc %h exp 0 4", imem_req, id_pc);
    end
    next_cyc();
    stall_en = 1'b0;
    compared++;
    if (imem_req !== 1'b0 || id_pc !== 32'h4 || id_valid !== 1'b1) begin
      mismatched++; $display("FAIL stall_hold2 got req %b pc %h v %b exp 0 4 1", imem_req, id_pc, id_valid);
    end
    next_cyc();
    compared++;
    if (imem_addr !== 32'hC || id_pc !== 32'h8 || id_instr !== (32'h8 ^ KEY)) begin
      mismatched++; $display("FAIL stall_release got addr %h pc %h instr %h exp c 8 %h", imem_addr, id_pc, id_instr, 32'h8 ^ KEY);
    end
    next_cyc();
    compared++;
    if (imem_addr !== 32'h10 || id_pc !== 32'hC) begin
      mismatched++; $display("FAIL stall_after got addr %h pc %h exp 10 c", imem_addr, id_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    compared++;
    if (perf_fetch_cnt !== 32'd4 || perf_flush_cnt !== 32'd0) begin
      mismatched++; $display("FAIL perf_mid got %0d/%0d exp 4/0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_redirect();
    pc_sel = 2'b01;
    ex_target = 32'h203;
    branch = 1'b1;
    next_cyc();
    pc_sel = 2'b00;
    branch = 1'b0;
    compared++;
    if (imem_addr !== 32'h200 || id_instr !== NOP || id_valid !== 1'b0) begin
      mismatched++; $display("FAIL redir_flush got addr %h instr %h v %b exp 200 %h 0", imem_addr, id_instr, id_valid, NOP);
    end
    next_cyc();
    compared++;
    if (id_pc !== 32'h200 || id_valid !== 1'b1 || imem_addr !== 32'h204) begin
      mismatched++; $display("FAIL redir_next got pc %h v %b addr %h exp 200 1 204", id_pc, id_valid, imem_addr);
    end
  endtask

  task automatic test_drop();
    pc_sel = 2'b01;
    ex_target = 32'h14;
    next_cyc();
    pc_sel = 2'b00;
    imem_ready = 1'b0;
    compared++;
    if (imem_addr !== 32'h14) begin mismatched++; $display("FAIL drop_setup got %h exp 14", imem_addr); end
    next_cyc();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      mismatched++; $display("FAIL drop_wait got req %b addr %h exp 1 14", imem_req, imem_addr);
    end
    pc_sel = 2'b01;
    ex_target = 32'h40;
    next_cyc();
    pc_sel = 2'b00;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14 || id_valid !== 1'b0) begin
      mismatched++; $display("FAIL drop_hold1 got req %b addr %h v %b exp 1 14 0", imem_req, imem_addr, id_valid);
    end
    next_cyc();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      mismatched++; $display("FAIL drop_hold2 got req %b addr %h exp 1 14", imem_req, imem_addr);
    end
    next_cyc();
    imem_ready = 1'b1;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      mismatched++; $display("FAIL drop_hold3 got req %b addr %h exp 1 14", imem_req, imem_addr);
    end
    next_cyc();
    compared++;
    if (imem_addr !== 32'h40 || id_valid !== 1'b0 || id_instr !== NOP) begin
      mismatched++; $display("FAIL drop_done got addr %h v %b instr %h exp 40 0 %h", imem_addr, id_valid, id_instr, NOP);
    end
    next_cyc();
    compared++;
    if (id_pc !== 32'h40 || id_instr !== (32'h40 ^ KEY) || imem_addr !== 32'h44) begin
      mismatched++; $display("FAIL drop_newpath got pc %h instr %h addr %h exp 40 %h 44", id_pc, id_instr, imem_addr, 32'h40 ^ KEY);
    end
  endtask

  task automatic test_trap_stall();
    pc_sel = 2'b10;
    stall_en = 1'b1;
    next_cyc();
    pc_sel = 2'b00;
    stall_en = 1'b0;
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0 || id_instr !== NOP) begin
      mismatched++; $display("FAIL trap got req %b addr %h v %b instr %h exp 1 100 0 %h", imem_req, imem_addr, id_valid, id_instr, NOP);
    end
    next_cyc();
    compared++;
    if (id_pc !== 32'h100 || imem_addr !== 32'h104) begin
      mismatched++; $display("FAIL trap_next got pc %h addr %h exp 100 104", id_pc, imem_addr);
    end
  endtask

  task automatic test_branch_flush();
    branch = 1'b1;
    next_cyc();
    branch = 1'b0;
    compared++;
    if (imem_addr !== 32'h104 || id_valid !== 1'b0 || id_instr !== NOP) begin
      mismatched++; $display("FAIL br_flush got addr %h v %b instr %h exp 104 0 %h", imem_addr, id_valid, id_instr, NOP);
    end
    next_cyc();
    compared++;
    if (id_pc !== 32'h104 || id_valid !== 1'b1 || imem_addr !== 32'h108) begin
      mismatched++; $display("FAIL br_refetch got pc %h v %b addr %h exp 104 1 108", id_pc, id_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    pc_sel = 2'b01;
    ex_target = 32'hFFFF_FFFF;
    next_cyc();
    pc_sel = 2'b00;
    compared++;
    if (imem_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    next_cyc();
    compared++;
    if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h5A5A_FFFC) begin
      mismatched++; $display("FAIL wrap_next got addr %h pc %h instr %h exp 0 fffffffc 5a5afffc", imem_addr, id_pc, id_instr);
    end
`ifdef FETCH_PERF_CNT_EN
    compared++;
    if (perf_fetch_cnt !== 32'd9 || perf_flush_cnt !== 32'd6) begin
      mismatched++; $display("FAIL perf_end got %0d/%0d exp 9/6", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    compared++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP) begin
      mismatched++; $display("FAIL rstmid got req %b v %b instr %h exp 0 0 %h", imem_req, id_valid, id_instr, NOP);
    end
    next_cyc();
    rst = 1'b0;
    imem_ready = 1'b1;
    compared++;
    if (imem_req !== 1'b0) begin mismatched++; $display("FAIL rstmid_idle got %b exp 0", imem_req); end
    next_cyc();
    compared++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      mismatched++; $display("FAIL rstmid_fetch got req %b addr %h exp 1 0", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_drop();
    test_trap_stall();
    test_branch_flush();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
